// File: rtl/ps2_key_receiver_pkg.sv
// rtl/ps2_key_receiver_pkg.sv - shared PS/2 constants, frame state type and parity helper
//
// Purpose: definitions shared by the PS/2 receiver files.
//   PS2_EXT / PS2_BRK : scan-code set 2 prefix bytes (extended, break)
//   frame_state_e     : frame FSM states
//   odd_parity_ok()   : 1 when data bits plus parity bit hold an odd count of ones
package ps2_key_receiver_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 pin synchronizer, clock glitch filter and falling-edge strobe
//
// Purpose: brings the asynchronous PS/2 pins into the clk domain and turns the
// filtered ps2_clk falling edge into a single-cycle sample strobe.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   ps2_clk_i       raw PS/2 clock pin
//   ps2_data_i      raw PS/2 data pin
//   fall_strobe_o   one-cycle pulse when the filtered clock goes 1 -> 0
//   data_sync_o     synchronized ps2_data, valid to sample with fall_strobe_o
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic fall_strobe_o,
  output logic data_sync_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    clk_sync_q;
  logic [1:0]    data_sync_q;
  logic          filt_q;
  logic [CW-1:0] cnt_q;
  logic          strobe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      filt_q      <= 1'b1;
      cnt_q       <= '0;
      strobe_q    <= 1'b0;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      strobe_q    <= 1'b0;
      // cnt_q counts consecutive samples that disagree with the filtered level;
      // any agreeing sample restarts the run, so short glitches never toggle it.
      if (clk_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q   <= clk_sync_q[1];
        cnt_q    <= '0;
        strobe_q <= filt_q;   // filtered level was 1, so this is a falling edge
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign fall_strobe_o = strobe_q;
  assign data_sync_o   = data_sync_q[1];

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 keyboard frame receiver and scan-code set 2 decoder
//
// Purpose: receives 11-bit PS/2 frames and turns scan-code set 2 bytes into
// single-cycle make/break events for the key-control logic.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw PS/2 pins (asynchronous)
//   key                 last decoded scan code, holds between events
//   key_pressed         one-cycle pulse on a make code
//   key_released        one-cycle pulse on a break code
//   key_ext             current key carried an E0 prefix
//   frame_error         one-cycle pulse on parity, stop-bit or timeout failure
module ps2_key_receiver
  import ps2_key_receiver_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int REPEAT_EN      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_pressed,
  output logic       key_released,
  output logic       key_ext,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic strobe;
  logic data_s;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_filter (
    .clk           (clk),
    .rst           (rst),
    .ps2_clk_i     (ps2_clk),
    .ps2_data_i    (ps2_data),
    .fall_strobe_o (strobe),
    .data_sync_o   (data_s)
  );

  frame_state_e  state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          par_q;
  logic [TW-1:0] to_cnt_q;
  logic          ext_pend_q;
  logic          brk_pend_q;
  logic          held_v_q;
  logic [7:0]    held_key_q;
  logic          held_ext_q;
  logic [7:0]    key_q;
  logic          ext_q;
  logic          kp_q;
  logic          kr_q;
  logic          fe_q;

  logic held_match;
  assign held_match = held_v_q && (held_key_q == shift_q) && (held_ext_q == ext_pend_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_cnt_q   <= '0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
      held_v_q   <= 1'b0;
      held_key_q <= '0;
      held_ext_q <= 1'b0;
      key_q      <= '0;
      ext_q      <= 1'b0;
      kp_q       <= 1'b0;
      kr_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      kp_q <= 1'b0;
      kr_q <= 1'b0;
      fe_q <= 1'b0;

      // Counts strobe-free cycles while a frame is open.
      if (state_q == ST_IDLE || strobe) to_cnt_q <= '0;
      else                              to_cnt_q <= to_cnt_q + TW'(1);

      case (state_q)
        ST_IDLE: begin
          if (strobe && !data_s) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= '0;
          end
        end
        ST_DATA: begin
          if (strobe) begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (strobe) begin
            par_q   <= data_s;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (strobe) begin
            state_q <= ST_IDLE;
            if (odd_parity_ok(shift_q, par_q) && data_s) begin
              if (shift_q == PS2_EXT) begin
                ext_pend_q <= 1'b1;
              end else if (shift_q == PS2_BRK) begin
                brk_pend_q <= 1'b1;
              end else begin
                ext_pend_q <= 1'b0;
                brk_pend_q <= 1'b0;
                if (brk_pend_q) begin
                  kr_q  <= 1'b1;
                  key_q <= shift_q;
                  ext_q <= ext_pend_q;
                  if (held_match) held_v_q <= 1'b0;
                end else begin
                  // A typematic repeat of the held key is swallowed when repeats are off.
                  if (REPEAT_EN != 0 || !held_match) begin
                    kp_q  <= 1'b1;
                    key_q <= shift_q;
                    ext_q <= ext_pend_q;
                  end
                  held_v_q   <= 1'b1;
                  held_key_q <= shift_q;
                  held_ext_q <= ext_pend_q;
                end
              end
            end else begin
              fe_q       <= 1'b1;
              ext_pend_q <= 1'b0;
              brk_pend_q <= 1'b0;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // A strobe in the same cycle always wins over the timeout.
      if (state_q != ST_IDLE && !strobe && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_q    <= ST_IDLE;
        fe_q       <= 1'b1;
        ext_pend_q <= 1'b0;
        brk_pend_q <= 1'b0;
      end
    end
  end

  assign key          = key_q;
  assign key_ext      = ext_q;
  assign key_pressed  = kp_q;
  assign key_released = kr_q;
  assign frame_error  = fe_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// tb/tb_ps2_key_receiver.sv - self-checking bench for ps2_key_receiver
module tb_ps2_key_receiver;

  localparam int FL = 8;
  localparam int TO = 200;
  localparam int H  = 20;

  typedef struct packed {
    logic [1:0] kind;   // 1 press, 2 release, 3 frame error
    logic [7:0] key;
    logic       ext;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    bit         bad_par;
    bit         bad_stop;
    logic [1:0] kind;
    logic [7:0] key;
    bit         ext;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  logic [7:0] a_key, b_key;
  logic a_kp, a_kr, a_ext, a_fe;
  logic b_kp, b_kr, b_ext, b_fe;

  int checks = 0;
  int failures = 0;
  int lat;

  ev_t act0[$], act1[$], exp0[$], exp1[$];

  bit         m_ext[2], m_brk[2], m_hv[2], m_he[2];
  logic [7:0] m_hk[2];

  always #5 clk = ~clk;

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .REPEAT_EN(1)) dut_a (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(a_key), .key_pressed(a_kp), .key_released(a_kr), .key_ext(a_ext), .frame_error(a_fe));

  ps2_key_receiver #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO), .REPEAT_EN(0)) dut_b (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key(b_key), .key_pressed(b_kp), .key_released(b_kr), .key_ext(b_ext), .frame_error(b_fe));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Event capture and per-cycle output rules.
  logic [7:0] pa_key, pb_key;
  logic pa_ext, pb_ext, pa_kp, pa_kr, pb_kp, pb_kr;
  initial begin
    pa_key = 0; pb_key = 0; pa_ext = 0; pb_ext = 0;
    pa_kp = 0; pa_kr = 0; pb_kp = 0; pb_kr = 0;
  end

  always @(negedge clk) begin
    ev_t e;
    if (!rst) begin
      checks++;
      if ((a_kp && a_kr) || (b_kp && b_kr) || (a_fe && (a_kp || a_kr)) || (b_fe && (b_kp || b_kr)) ||
          (((a_key != pa_key) || (a_ext != pa_ext)) && !(a_kp || a_kr)) ||
          (((b_key != pb_key) || (b_ext != pb_ext)) && !(b_kp || b_kr)) ||
          (a_kp && pa_kp) || (a_kr && pa_kr) || (b_kp && pb_kp) || (b_kr && pb_kr)) begin
        failures++;
        $display("FAIL output_rules actual=a:%b%b%b b:%b%b%b required=exclusive single-cycle pulses, key stable",
                 a_kp, a_kr, a_fe, b_kp, b_kr, b_fe);
      end
    end
    if (a_kp) begin e.kind = 2'd1; e.key = a_key; e.ext = a_ext; act0.push_back(e); end
    if (a_kr) begin e.kind = 2'd2; e.key = a_key; e.ext = a_ext; act0.push_back(e); end
    if (a_fe) begin e.kind = 2'd3; e.key = 8'h00; e.ext = 1'b0; act0.push_back(e); end
    if (b_kp) begin e.kind = 2'd1; e.key = b_key; e.ext = b_ext; act1.push_back(e); end
    if (b_kr) begin e.kind = 2'd2; e.key = b_key; e.ext = b_ext; act1.push_back(e); end
    if (b_fe) begin e.kind = 2'd3; e.key = 8'h00; e.ext = 1'b0; act1.push_back(e); end
    pa_key = a_key; pa_ext = a_ext; pa_kp = a_kp; pa_kr = a_kr;
    pb_key = b_key; pb_ext = b_ext; pb_kp = b_kp; pb_kr = b_kr;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: byte-level scan-code rules, one state set per instance.
  task automatic push(input int d, input logic [1:0] kind, input logic [7:0] k, input logic x);
    ev_t e;
    e.kind = kind; e.key = k; e.ext = x;
    if (d == 0) exp0.push_back(e); else exp1.push_back(e);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_ext[d] = 0; m_brk[d] = 0; m_hv[d] = 0; m_he[d] = 0; m_hk[d] = 8'h00;
    end
  endtask

  task automatic model_byte(input int d, input logic [7:0] b, input bit good);
    bit same;
    if (!good) begin
      push(d, 2'd3, 8'h00, 1'b0);
      m_ext[d] = 0; m_brk[d] = 0;
    end else if (b == 8'hE0) begin
      m_ext[d] = 1;
    end else if (b == 8'hF0) begin
      m_brk[d] = 1;
    end else begin
      same = m_hv[d] && (m_hk[d] == b) && (m_he[d] == m_ext[d]);
      if (m_brk[d]) begin
        push(d, 2'd2, b, m_ext[d]);
        if (same) m_hv[d] = 0;
      end else begin
        if (d == 0 || !same) push(d, 2'd1, b, m_ext[d]);
        m_hv[d] = 1; m_hk[d] = b; m_he[d] = m_ext[d];
      end
      m_ext[d] = 0; m_brk[d] = 0;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    lat = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ps2_data = bits[k];
      tick(H);
      ps2_clk = 1'b0;
      for (int i = 1; i <= H; i++) begin
        @(posedge clk);
        #1;
        if (lat == 0 && (a_kp || a_kr || a_fe)) lat = i;
        @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    tick(H);
    ps2_data = 1'b1;
    tick(H);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bits({~bad_stop, par, b, 1'b0}, 11);
    model_byte(0, b, !(bad_par || bad_stop));
    model_byte(1, b, !(bad_par || bad_stop));
  endtask

  task automatic cmp_dut(input string tag, input int d);
    int na, ne;
    ev_t a, e;
    na = (d == 0) ? act0.size() : act1.size();
    ne = (d == 0) ? exp0.size() : exp1.size();
    chk({tag, "_count"}, na, ne);
    for (int i = 0; i < na && i < ne; i++) begin
      a = (d == 0) ? act0[i] : act1[i];
      e = (d == 0) ? exp0[i] : exp1[i];
      chk({tag, "_event"}, {21'd0, a}, {21'd0, e});
    end
    if (d == 0) begin act0.delete(); exp0.delete(); end
    else        begin act1.delete(); exp1.delete(); end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a_key"}, a_key, 8'h00);
    chk({tag, "_a_flags"}, {a_ext, a_kp, a_kr, a_fe}, 4'b0000);
    chk({tag, "_b_key"}, b_key, 8'h00);
    chk({tag, "_b_flags"}, {b_ext, b_kp, b_kr, b_fe}, 4'b0000);
  endtask

  vec_t tbl[13];

  initial begin
    int np, nr;
    logic [7:0] pool[7];
    tbl[0]  = '{8'h1D, 0, 0, 2'd1, 8'h1D, 0};
    tbl[1]  = '{8'hF0, 0, 0, 2'd0, 8'h00, 0};
    tbl[2]  = '{8'h1D, 0, 0, 2'd2, 8'h1D, 0};
    tbl[3]  = '{8'hE0, 0, 0, 2'd0, 8'h00, 0};
    tbl[4]  = '{8'h75, 0, 0, 2'd1, 8'h75, 1};
    tbl[5]  = '{8'hE0, 0, 0, 2'd0, 8'h00, 0};
    tbl[6]  = '{8'hF0, 0, 0, 2'd0, 8'h00, 0};
    tbl[7]  = '{8'h75, 0, 0, 2'd2, 8'h75, 1};
    tbl[8]  = '{8'h5A, 0, 0, 2'd1, 8'h5A, 0};
    tbl[9]  = '{8'h1B, 1, 0, 2'd3, 8'h00, 0};
    tbl[10] = '{8'h29, 0, 0, 2'd1, 8'h29, 0};
    tbl[11] = '{8'h33, 0, 1, 2'd3, 8'h00, 0};
    tbl[12] = '{8'h29, 0, 0, 2'd1, 8'h29, 0};
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h75, 8'h5A, 8'h29, 8'h1D};

    model_reset();
    tick(4);
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick(4);

    // Directed table on the repeat-passing instance; the other follows the model.
    for (int i = 0; i < 13; i++) begin
      ev_t e;
      frame(tbl[i].b, tbl[i].bad_par, tbl[i].bad_stop);
      chk($sformatf("tbl%0d_count", i), act0.size(), (tbl[i].kind != 2'd0) ? 1 : 0);
      if (tbl[i].kind != 2'd0) begin
        e.kind = tbl[i].kind; e.key = tbl[i].key; e.ext = tbl[i].ext;
        if (act0.size() > 0) chk($sformatf("tbl%0d_event", i), {21'd0, act0[0]}, {21'd0, e});
        chk($sformatf("tbl%0d_latency", i), lat, FL + 3);
      end
      act0.delete(); exp0.delete();
      cmp_dut($sformatf("tbl%0d_b", i), 1);
    end

    // Randomized byte stream with occasional corrupted frames.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      bit bad, which;
      b = pool[$urandom_range(0, 6)];
      bad = ($urandom_range(0, 7) == 0);
      which = $urandom_range(0, 1);
      frame(b, bad && which, bad && !which);
      cmp_dut($sformatf("rand%0d_a", i), 0);
      cmp_dut($sformatf("rand%0d_b", i), 1);
    end

    // Partial frame then silence: timeout error, then normal decode.
    send_bits({6'h3F, 4'b0101, 1'b0}, 5);
    tick(TO + 50);
    model_byte(0, 8'h00, 0);
    model_byte(1, 8'h00, 0);
    cmp_dut("timeout_a", 0);
    cmp_dut("timeout_b", 1);
    frame(8'h23, 0, 0);
    chk("after_timeout_key", a_key, 8'h23);
    cmp_dut("after_timeout_a", 0);
    cmp_dut("after_timeout_b", 1);

    // Reset in the middle of a frame: silent discard.
    send_bits({7'h7F, 3'b110, 1'b0}, 4);
    @(negedge clk);
    rst = 1'b1;
    tick(2);
    chk_reset_outputs("midreset");
    rst = 1'b0;
    model_reset();
    tick(TO + 50);
    cmp_dut("midreset_a", 0);
    cmp_dut("midreset_b", 1);

    // Short clock glitch while data is low must not look like a start bit.
    @(negedge clk);
    ps2_data = 1'b0;
    tick(H);
    ps2_clk = 1'b0;
    tick(FL - 2);
    ps2_clk = 1'b1;
    tick(H);
    ps2_data = 1'b1;
    tick(TO + 50);
    frame(8'h2B, 0, 0);
    chk("glitch_key", a_key, 8'h2B);
    cmp_dut("glitch_a", 0);
    cmp_dut("glitch_b", 1);

    // Typematic stream: 1D x3, F0 1D, 1D.
    frame(8'h1D, 0, 0);
    frame(8'h1D, 0, 0);
    frame(8'h1D, 0, 0);
    frame(8'hF0, 0, 0);
    frame(8'h1D, 0, 0);
    frame(8'h1D, 0, 0);
    np = 0; nr = 0;
    foreach (act1[i]) begin
      if (act1[i].kind == 2'd1) np++;
      if (act1[i].kind == 2'd2) nr++;
    end
    chk("norepeat_presses", np, 2);
    chk("norepeat_releases", nr, 1);
    np = 0; nr = 0;
    foreach (act0[i]) begin
      if (act0[i].kind == 2'd1) np++;
      if (act0[i].kind == 2'd2) nr++;
    end
    chk("repeat_presses", np, 4);
    chk("repeat_releases", nr, 1);
    cmp_dut("repeat_a", 0);
    cmp_dut("repeat_b", 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
